icb_crypto_slave_gen: RTL and testbench

// - Parametrised ICB slave register front-end for the crypto bridge: CONTROL/STATUS/WDATA/RDATA/KEYn map.
// - WDATA writes push to the cipher input; RDATA reads pop the result FIFO (show-ahead).
// - Adds N key slots with select, error responses, sticky W1C status and one-outstanding rsp handshake.

---
 rtl/icb_crypto_pkg.sv | 21 ++
 rtl/icb_rsp_slot.sv | 39 +++
 rtl/icb_crypto_slave_gen.sv | 131 +++++++++++++
 tb/tb_icb_crypto_slave_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_crypto_pkg.sv
// icb_crypto_pkg: register map offsets, STATUS bit indices and the CONTROL layout
// shared by the crypto bridge ICB front-end.
package icb_crypto_pkg;
   localparam logic [7:0] OFF_CTRL  = 8'h00;
   localparam logic [7:0] OFF_STAT  = 8'h08;
   localparam logic [7:0] OFF_WDATA = 8'h10;
   localparam logic [7:0] OFF_RDATA = 8'h18;
   localparam logic [7:0] OFF_KEY0  = 8'h20;
   localparam int ST_WFULL  = 0;
   localparam int ST_REMPTY = 1;
   localparam int ST_UFLOW  = 2;
   localparam int ST_DECERR = 3;
   localparam int CTRL_W    = 7;
   typedef struct packed {
      logic       irq_en_err;
      logic       irq_en_ovf;
      logic [2:0] key_sel;
      logic       mode;
      logic       en;
   } ctrl_t;
endpackage

// File: rtl/icb_rsp_slot.sv
// icb_rsp_slot: one-entry ICB response register; a load in the drain cycle
// replaces the entry so back-to-back commands see no bubble.
module icb_rsp_slot #(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] ld_rdata,
   input  logic          ld_err,
   input  logic          rsp_ready,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          free
);
   logic          valid_q, valid_d, err_q, err_d;
   logic [DW-1:0] rdata_q, rdata_d;
   always_comb begin
      valid_d = load || (valid_q && !rsp_ready);
      rdata_d = load ? ld_rdata : rdata_q;
      err_d   = load ? ld_err : err_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   assign free      = !valid_q || rsp_ready;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
endmodule

// File: rtl/icb_crypto_slave_gen.sv
// icb_crypto_slave_gen: ICB register front-end for the crypto bridge; decodes the
// CONTROL/STATUS/WDATA/RDATA/KEYn map and holds the register file.
module icb_crypto_slave_gen
   import icb_crypto_pkg::*;
#(
   parameter int            DW        = 64,
   parameter int            AW        = 32,
   parameter logic [AW-1:0] BASE_ADDR = 32'h2000_0000,
   parameter int            NUM_KEYS  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            icb_cmd_valid,
   output logic            icb_cmd_ready,
   input  logic [AW-1:0]   icb_cmd_addr,
   input  logic            icb_cmd_read,
   input  logic [DW-1:0]   icb_cmd_wdata,
   input  logic [DW/8-1:0] icb_cmd_wmask,
   output logic            icb_rsp_valid,
   input  logic            icb_rsp_ready,
   output logic [DW-1:0]   icb_rsp_rdata,
   output logic            icb_rsp_err,
   input  logic            wfull,
   output logic [DW-1:0]   wdata,
   output logic            wdata_vld,
   input  logic            rempty,
   input  logic [DW-1:0]   rdata,
   output logic            rdata_en,
   output logic [DW-1:0]   key,
   output logic            ctrl_en,
   output logic            ctrl_mode,
   output logic            irq
);
   localparam logic [4:0] NK = 5'(NUM_KEYS);
   ctrl_t         ctrl_q, ctrl_d, ctrl_w;
   logic [DW-1:0] key_q [NUM_KEYS];
   logic [DW-1:0] key_d [NUM_KEYS];
   logic [DW-1:0] wdata_q, wdata_d, bm, kval, rsp_d;
   logic          wdata_vld_q, wdata_vld_d, uf_q, uf_d, dec_q, dec_d;
   logic [3:0]    stat;
   logic [7:0]    off;
   logic [4:0]    kidx;
   logic          base_hit, is_ctrl, is_stat, is_wd, is_rd, is_key;
   logic          dec_err, uflow, stall, free, acc, wr_ok, stat_clr;

   assign off      = icb_cmd_addr[7:0];
   assign kidx     = off[7:3] - OFF_KEY0[7:3];
   assign base_hit = icb_cmd_addr[AW-1:8] == BASE_ADDR[AW-1:8];
   assign is_ctrl  = off == OFF_CTRL;
   assign is_stat  = off == OFF_STAT;
   assign is_wd    = off == OFF_WDATA;
   assign is_rd    = off == OFF_RDATA;
   assign is_key   = off >= OFF_KEY0 && off[2:0] == 3'd0 && kidx < NK;

   always_comb begin
      bm = '0;
      for (int i = 0; i < DW/8; i++) bm[i*8 +: 8] = {8{!icb_cmd_wmask[i]}};
      ctrl_w = ctrl_t'((icb_cmd_wdata[CTRL_W-1:0] & bm[CTRL_W-1:0]) | (ctrl_q & ~bm[CTRL_W-1:0]));
      stat = '0;
      stat[ST_WFULL]  = wfull;
      stat[ST_REMPTY] = rempty;
      stat[ST_UFLOW]  = uf_q;
      stat[ST_DECERR] = dec_q;
      kval = '0;
      key  = '0;
      for (int n = 0; n < NUM_KEYS; n++) begin
         kval = (kidx == 5'(n)) ? key_q[n] : kval;
         key  = ({2'b0, ctrl_q.key_sel} == 5'(n)) ? key_q[n] : key;
      end
   end

   // A CONTROL write selecting a missing key slot is rejected like a bad address.
   assign dec_err = !base_hit || !(is_ctrl || is_stat || is_wd || is_rd || is_key) ||
                    (icb_cmd_read ? is_wd : (is_rd || (is_ctrl && {2'b0, ctrl_w.key_sel} >= NK)));
   assign uflow         = !dec_err && icb_cmd_read && is_rd && rempty;
   assign stall         = base_hit && is_wd && !icb_cmd_read && wfull;
   assign acc           = icb_cmd_valid && free && !stall;
   assign wr_ok         = acc && !dec_err && !icb_cmd_read;
   assign stat_clr      = wr_ok && is_stat && !icb_cmd_wmask[0];
   assign icb_cmd_ready = acc;
   assign rdata_en      = acc && icb_cmd_read && is_rd && !dec_err && !rempty;

   always_comb begin
      rsp_d = (icb_cmd_read && !dec_err && !uflow) ?
              (is_ctrl ? DW'(ctrl_q) : is_stat ? DW'(stat) : is_rd ? rdata : kval) : '0;
      ctrl_d      = (wr_ok && is_ctrl) ? ctrl_w : ctrl_q;
      wdata_vld_d = wr_ok && is_wd;
      wdata_d     = wdata_vld_d ? (icb_cmd_wdata & bm) | (wdata_q & ~bm) : wdata_q;
      uf_d        = (acc && uflow) || (uf_q && !(stat_clr && icb_cmd_wdata[ST_UFLOW]));
      dec_d       = (acc && dec_err) || (dec_q && !(stat_clr && icb_cmd_wdata[ST_DECERR]));
      for (int n = 0; n < NUM_KEYS; n++)
         key_d[n] = (wr_ok && is_key && kidx == 5'(n)) ? (icb_cmd_wdata & bm) | (key_q[n] & ~bm) : key_q[n];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q      <= '0;
         wdata_q     <= '0;
         wdata_vld_q <= 1'b0;
         uf_q        <= 1'b0;
         dec_q       <= 1'b0;
         for (int n = 0; n < NUM_KEYS; n++) key_q[n] <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         wdata_q     <= wdata_d;
         wdata_vld_q <= wdata_vld_d;
         uf_q        <= uf_d;
         dec_q       <= dec_d;
         key_q       <= key_d;
      end
   end

   icb_rsp_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (acc),
      .ld_rdata  (rsp_d),
      .ld_err    (dec_err || uflow),
      .rsp_ready (icb_rsp_ready),
      .rsp_valid (icb_rsp_valid),
      .rsp_rdata (icb_rsp_rdata),
      .rsp_err   (icb_rsp_err),
      .free      (free)
   );

   assign wdata     = wdata_q;
   assign wdata_vld = wdata_vld_q;
   assign ctrl_en   = ctrl_q.en;
   assign ctrl_mode = ctrl_q.mode;
   assign irq       = (uf_q && ctrl_q.irq_en_ovf) || (dec_q && ctrl_q.irq_en_err);
endmodule

// File: tb/tb_icb_crypto_slave_gen.sv
// tb_icb_crypto_slave_gen: directed vector table, stall/hold/reset sequences and
// random traffic checked against a register-map model of the crypto slave.
module tb_icb_crypto_slave_gen;
   localparam logic [31:0] BASE = 32'h2000_0000;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        icb_cmd_valid = 1'b0, icb_cmd_read = 1'b0, icb_rsp_ready = 1'b1;
   logic [31:0] icb_cmd_addr = '0;
   logic [63:0] icb_cmd_wdata = '0, rdata = '0;
   logic [7:0]  icb_cmd_wmask = '0;
   logic        wfull = 1'b0, rempty = 1'b1;
   logic        icb_cmd_ready, icb_rsp_valid, icb_rsp_err, wdata_vld, rdata_en, ctrl_en, ctrl_mode, irq;
   logic [63:0] icb_rsp_rdata, wdata, key;
   int          n_chk = 0, n_pass = 0, vld_cnt = 0;
   logic [7:0]  offs [9] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h40, 8'h04};

   logic [6:0]  m_ctrl;
   logic [63:0] m_keys [2];
   logic [63:0] m_stage;
   logic        m_uf, m_dec;
   int          m_push = 0;

   typedef struct {
      logic [31:0] a;
      logic        rd;
      logic [63:0] wd;
      logic [7:0]  wm;
      logic        re;
      logic [63:0] rdi;
      logic [63:0] ed;
      logic        ee;
      logic        ei;
   } vec_t;
   vec_t tv [21];

   icb_crypto_slave_gen #(.DW(64), .AW(32), .BASE_ADDR(32'h2000_0000), .NUM_KEYS(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
      .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
      .icb_rsp_err(icb_rsp_err), .wfull(wfull), .wdata(wdata), .wdata_vld(wdata_vld),
      .rempty(rempty), .rdata(rdata), .rdata_en(rdata_en), .key(key),
      .ctrl_en(ctrl_en), .ctrl_mode(ctrl_mode), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (wdata_vld) vld_cnt++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [63:0] mrg(input logic [63:0] o, input logic [63:0] w, input logic [7:0] m);
      for (int b = 0; b < 8; b++) mrg[b*8 +: 8] = m[b] ? o[b*8 +: 8] : w[b*8 +: 8];
   endfunction

   task automatic mreset();
      m_ctrl = '0; m_keys[0] = '0; m_keys[1] = '0; m_stage = '0; m_uf = 0; m_dec = 0;
   endtask

   // Register-map reference: applies one accepted command, returns the expected response.
   task automatic model(input logic [31:0] a, input logic rd, input logic [63:0] wd, input logic [7:0] wm,
                        output logic [63:0] d, output logic e, output logic p);
      logic [7:0] o;
      logic [63:0] nv;
      logic u;
      int k;
      o = a[7:0]; d = 0; e = 0; p = 0; u = 0;
      k = (o >= 8'h20 && o % 8 == 0) ? (int'(o) - 32) / 8 : -1;
      if (a[31:8] != BASE[31:8]) e = 1;
      else if (o == 8'h00) begin
         nv = mrg({57'b0, m_ctrl}, wd, wm);
         if (rd) d = {57'b0, m_ctrl};
         else if (nv[4:2] >= 2) e = 1;
         else m_ctrl = nv[6:0];
      end else if (o == 8'h08) begin
         nv = mrg(64'b0, wd, wm);
         if (rd) d = {60'b0, m_dec, m_uf, rempty, wfull};
         else begin
            if (nv[2]) m_uf = 0;
            if (nv[3]) m_dec = 0;
         end
      end else if (o == 8'h10) begin
         if (rd) e = 1;
         else begin m_stage = mrg(m_stage, wd, wm); p = 1; m_push++; end
      end else if (o == 8'h18) begin
         if (!rd) e = 1;
         else if (rempty) begin e = 1; u = 1; m_uf = 1; end
         else d = rdata;
      end else if (k >= 0 && k < 2) begin
         if (rd) d = m_keys[k];
         else m_keys[k] = mrg(m_keys[k], wd, wm);
      end else e = 1;
      if (e && !u) m_dec = 1;
   endtask

   task automatic run(input logic [31:0] a, input logic rd, input logic [63:0] wd, input logic [7:0] wm,
                      input int rel, output logic [63:0] gd, output logic ge);
      int w, exp_w, ks;
      logic [63:0] ed, ek;
      logic ee, ep;
      @(negedge clk);
      icb_cmd_valid = 1; icb_cmd_addr = a; icb_cmd_read = rd; icb_cmd_wdata = wd; icb_cmd_wmask = wm;
      exp_w = (a[31:8] == BASE[31:8] && a[7:0] == 8'h10 && !rd && wfull) ? rel : 0;
      #1;
      w = 0;
      while (!icb_cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
         if (w == rel) wfull = 0;
         #1;
      end
      chk("cmd_accept", icb_cmd_ready, 1);
      chk("stall_cycles", 64'(w), 64'(exp_w));
      chk("rdata_en", rdata_en, a[31:8] == BASE[31:8] && a[7:0] == 8'h18 && rd && !rempty);
      model(a, rd, wd, wm, ed, ee, ep);
      @(negedge clk);
      icb_cmd_valid = 0;
      #1;
      gd = icb_rsp_rdata; ge = icb_rsp_err;
      ks = int'(m_ctrl[4:2]);
      ek = (ks < 2) ? m_keys[ks] : 64'b0;
      chk("rsp_valid", icb_rsp_valid, 1);
      chk("rsp_rdata", icb_rsp_rdata, ed);
      chk("rsp_err", icb_rsp_err, ee);
      chk("wdata_vld", wdata_vld, ep);
      chk("wdata", wdata, m_stage);
      chk("key", key, ek);
      chk("ctrl", {ctrl_mode, ctrl_en}, m_ctrl[1:0]);
      chk("irq", irq, (m_uf && m_ctrl[5]) || (m_dec && m_ctrl[6]));
   endtask

   initial begin
      logic [63:0] d, wd;
      logic e, rd;
      logic [31:0] a;
      logic [7:0] wm;
      int sel, c0;
      mreset();
      tv[0]  = '{BASE | 32'h28, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0};
      tv[1]  = '{BASE | 32'h28, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h0123_4567_0000_0000, 1'b0, 1'b0};
      tv[2]  = '{BASE | 32'h00, 1'b0, 64'h7, 8'h00, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0};
      tv[3]  = '{BASE | 32'h00, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h7, 1'b0, 1'b0};
      tv[4]  = '{BASE | 32'h18, 1'b1, 64'h0, 8'h00, 1'b0, 64'hA5A5, 64'hA5A5, 1'b0, 1'b0};
      tv[5]  = '{BASE | 32'h18, 1'b1, 64'h0, 8'h00, 1'b1, 64'hA5A5, 64'h0, 1'b1, 1'b0};
      tv[6]  = '{BASE | 32'h08, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h6, 1'b0, 1'b0};
      tv[7]  = '{BASE | 32'h08, 1'b0, 64'h4, 8'h00, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0};
      tv[8]  = '{BASE | 32'h08, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h2, 1'b0, 1'b0};
      tv[9]  = '{BASE | 32'h40, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h0, 1'b1, 1'b0};
      tv[10] = '{BASE | 32'h00, 1'b0, 64'h14, 8'h00, 1'b1, 64'h0, 64'h0, 1'b1, 1'b0};
      tv[11] = '{BASE | 32'h00, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h7, 1'b0, 1'b0};
      tv[12] = '{BASE | 32'h08, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'hA, 1'b0, 1'b0};
      tv[13] = '{BASE | 32'h00, 1'b0, 64'h47, 8'h00, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1};
      tv[14] = '{BASE | 32'h18, 1'b0, 64'h1, 8'h00, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1};
      tv[15] = '{BASE | 32'h10, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h0, 1'b1, 1'b1};
      tv[16] = '{32'h3000_0000, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h0, 1'b1, 1'b1};
      tv[17] = '{BASE | 32'h04, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h0, 1'b1, 1'b1};
      tv[18] = '{BASE | 32'h30, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h0, 1'b1, 1'b1};
      tv[19] = '{BASE | 32'h08, 1'b0, 64'h8, 8'h00, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0};
      tv[20] = '{BASE | 32'h20, 1'b1, 64'h0, 8'h00, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0};

      #12;
      chk("rst_cmd_ready", icb_cmd_ready, 0);
      chk("rst_rsp", {icb_rsp_valid, icb_rsp_err, wdata_vld, rdata_en}, 0);
      chk("rst_ctrl_irq", {ctrl_en, ctrl_mode, irq}, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_key", key, 0);
      chk("rst_rsp_rdata", icb_rsp_rdata, 0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 21; i++) begin
         rempty = tv[i].re; rdata = tv[i].rdi; wfull = 0;
         run(tv[i].a, tv[i].rd, tv[i].wd, tv[i].wm, 1, d, e);
         chk($sformatf("vec%0d_rdata", i), d, tv[i].ed);
         chk($sformatf("vec%0d_err", i), e, tv[i].ee);
         chk($sformatf("vec%0d_irq", i), irq, tv[i].ei);
      end

      c0 = vld_cnt;
      wfull = 1;
      run(BASE | 32'h10, 1'b0, 64'hDEAD_BEEF_0000_0001, 8'h00, 3, d, e);
      @(negedge clk);
      #1;
      chk("stall_pulses", 64'(vld_cnt - c0), 1);
      chk("stall_word", wdata, 64'hDEAD_BEEF_0000_0001);

      for (int it = 0; it < 300; it++) begin
         sel = $urandom_range(0, 9);
         a = (sel == 9) ? 32'h2000_1008 : (BASE | {24'b0, offs[sel]});
         rd = 1'($urandom);
         wd = {$urandom, $urandom};
         if (sel == 0 && $urandom_range(0, 1) == 1) wd[4:2] = 3'($urandom_range(0, 1));
         wm = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
         rempty = 1'($urandom);
         rdata = {$urandom, $urandom};
         wfull = ($urandom_range(0, 2) == 0);
         run(a, rd, wd, wm, $urandom_range(1, 3), d, e);
      end
      wfull = 0;

      @(negedge clk);
      icb_rsp_ready = 0; icb_cmd_valid = 1; icb_cmd_read = 1; icb_cmd_addr = BASE;
      #1;
      chk("hold_first_ready", icb_cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("hold_valid", icb_rsp_valid, 1);
         chk("hold_rdata", icb_rsp_rdata, {57'b0, m_ctrl});
         chk("hold_err", icb_rsp_err, 0);
         chk("hold_no_ready", icb_cmd_ready, 0);
      end
      #2;
      icb_cmd_valid = 0; rst_n = 0;
      #1;
      chk("async_rst_valid", icb_rsp_valid, 0);
      chk("async_rst_ctrl", {ctrl_en, ctrl_mode, irq}, 0);
      chk("async_rst_key", key, 0);
      @(negedge clk);
      rst_n = 1; icb_rsp_ready = 1;
      mreset();

      @(negedge clk);
      icb_cmd_valid = 1; icb_cmd_read = 1; icb_cmd_addr = BASE;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_ready", icb_cmd_ready, 1);
         if (i > 0) chk("b2b_valid", icb_rsp_valid, 1);
         @(negedge clk);
         #1;
      end
      icb_cmd_valid = 0;
      chk("b2b_last_valid", icb_rsp_valid, 1);
      chk("b2b_rdata", icb_rsp_rdata, 0);
      @(negedge clk);
      #1;
      chk("b2b_drain", icb_rsp_valid, 0);
      chk("push_count", 64'(vld_cnt), 64'(m_push));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
